// File: rtl/cache_fill_ctrl.sv
// Miss-handling and replacement controller for a set-associative cache.
// Accepts lookups in IDLE, answers hits in one cycle, and on a miss picks a
// victim (first invalid way, else true-LRU), runs a fill handshake with
// memory and marks the filled line valid through the valid-array write port.
module cache_fill_ctrl #(
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    localparam int SETS      = TOTAL_SIZE / WAYS,
    localparam int IW        = $clog2(SETS),
    localparam int WW        = $clog2(WAYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [IW-1:0] req_index,
    output logic          req_ready,
    input  logic          hit,
    input  logic [WW-1:0] hit_way,
    input  logic          valid_in [0:WAYS-1],
    output logic          valid_we,
    output logic [WW-1:0] valid_way,
    output logic [IW-1:0] valid_index,
    output logic          mem_req,
    output logic [WW-1:0] mem_way,
    output logic [IW-1:0] mem_index,
    input  logic          mem_ack,
    output logic          resp_valid,
    output logic          resp_hit,
    output logic [WW-1:0] resp_way
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]    state_reg;
    logic [IW-1:0] index_reg;
    logic [WW-1:0] victim_reg;
    logic          resp_valid_reg;
    logic          resp_hit_reg;
    logic [WW-1:0] resp_way_reg;

    // Per-set age table: 0 = MRU, WAYS-1 = LRU; each set holds a permutation.
    logic [WW-1:0] age_reg [SETS][WAYS];

    logic [WAYS-1:0] invalid_mask;
    logic            eff_hit;
    logic            accept;
    logic [WW-1:0]   victim_next;
    logic            touch_en;
    logic [IW-1:0]   touch_set;
    logic [WW-1:0]   touch_way;
    logic [WW-1:0]   touch_age;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_inv
            assign invalid_mask[gi] = ~valid_in[gi];
        end
    endgenerate

    // A tag match on an invalid way is not a real hit.
    assign eff_hit = hit && valid_in[hit_way];
    assign accept  = (state_reg == ST_IDLE) && req_valid;

    // Victim choice: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        logic [WW-1:0] inv_way;
        logic [WW-1:0] lru_way;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (invalid_mask[w]) inv_way = WW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (age_reg[req_index][w] == WW'(WAYS - 1)) lru_way = WW'(w);
        end
        victim_next = (|invalid_mask) ? inv_way : lru_way;
    end

    // At most one LRU touch per cycle: an IDLE hit or the WRITE of a fill.
    always_comb begin
        touch_en  = (accept && eff_hit) || (state_reg == ST_WRITE);
        touch_set = (state_reg == ST_WRITE) ? index_reg  : req_index;
        touch_way = (state_reg == ST_WRITE) ? victim_reg : hit_way;
        touch_age = age_reg[touch_set][touch_way];
    end

    // LRU ages: touched way becomes MRU, younger ways age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_reg[s][w] <= WW'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == touch_way) begin
                    age_reg[touch_set][w] <= '0;
                end else if (age_reg[touch_set][w] < touch_age) begin
                    age_reg[touch_set][w] <= age_reg[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Control FSM plus the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            index_reg      <= '0;
            victim_reg     <= '0;
            resp_valid_reg <= 1'b0;
            resp_hit_reg   <= 1'b0;
            resp_way_reg   <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (eff_hit) begin
                            resp_valid_reg <= 1'b1;
                            resp_hit_reg   <= 1'b1;
                            resp_way_reg   <= hit_way;
                        end else begin
                            index_reg  <= req_index;
                            victim_reg <= victim_next;
                            state_reg  <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (mem_ack) state_reg <= ST_WRITE;
                end
                ST_WRITE: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b1;
                    resp_hit_reg   <= 1'b0;
                    resp_way_reg   <= victim_reg;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign mem_req     = (state_reg == ST_FILL);
    assign mem_way     = victim_reg;
    assign mem_index   = index_reg;
    assign valid_we    = (state_reg == ST_WRITE);
    assign valid_way   = victim_reg;
    assign valid_index = (state_reg == ST_IDLE) ? req_index : index_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_hit    = resp_hit_reg;
    assign resp_way    = resp_way_reg;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Testbench for cache_fill_ctrl: directed vector table, back-to-back hits,
// reset during fill, and randomized lookups against an LRU reference model.
module tb_cache_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_index;
    logic       req_ready;
    logic       hit;
    logic [1:0] hit_way;
    logic       valid_in [0:3];
    logic       valid_we;
    logic [1:0] valid_way;
    logic [1:0] valid_index;
    logic       mem_req;
    logic [1:0] mem_way;
    logic [1:0] mem_index;
    logic       mem_ack;
    logic       resp_valid;
    logic       resp_hit;
    logic [1:0] resp_way;

    int total = 0;
    int bad   = 0;

    // Reference LRU ages: m_age[set][way], 0 = MRU, 3 = LRU.
    int m_age [4][4];

    cache_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .hit        (hit),
        .hit_way    (hit_way),
        .valid_in   (valid_in),
        .valid_we   (valid_we),
        .valid_way  (valid_way),
        .valid_index(valid_index),
        .mem_req    (mem_req),
        .mem_way    (mem_way),
        .mem_index  (mem_index),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic       hit;
        logic [1:0] hw;
        logic [3:0] valid;   // bit w = valid bit of way w
        int         delay;   // FILL cycles before mem_ack
        logic       exp_hit;
        logic [1:0] exp_way;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_valid(input logic [3:0] v);
        for (int i = 0; i < 4; i++) valid_in[i] = v[i];
    endtask

    task automatic m_reset();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++) m_age[s][w] = w;
    endtask

    task automatic m_touch(input int s, input int w);
        int a;
        a = m_age[s][w];
        for (int v = 0; v < 4; v++)
            if (m_age[s][v] < a) m_age[s][v]++;
        m_age[s][w] = 0;
    endtask

    function automatic int m_victim(input int s, input logic [3:0] v);
        for (int w = 0; w < 4; w++)
            if (!v[w]) return w;
        for (int w = 0; w < 4; w++)
            if (m_age[s][w] == 3) return w;
        return 0;
    endfunction

    // One complete lookup starting and ending at a negedge with the DUT idle.
    task automatic run_txn(input logic [1:0] idx, input logic h, input logic [1:0] hw,
                           input logic [3:0] v, input int delay,
                           input logic exp_hit, input logic [1:0] exp_way);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_index = idx;
        hit       = h;
        hit_way   = hw;
        set_valid(v);
        #1;
        chk("valid_index_idle", valid_index, idx);
        cyc();
        req_valid = 1'b0;
        hit       = 1'b0;
        if (exp_hit) begin
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_hit", resp_hit, 1);
            chk("hit_resp_way", resp_way, exp_way);
            chk("hit_no_mem_req", mem_req, 0);
        end else begin
            for (int k = 1; k <= delay; k++) begin
                chk("fill_mem_req", mem_req, 1);
                chk("fill_mem_way", mem_way, exp_way);
                chk("fill_mem_index", mem_index, idx);
                chk("fill_req_ready", req_ready, 0);
                chk("fill_no_we", valid_we, 0);
                mem_ack = (k == delay);
                cyc();
            end
            mem_ack = 1'b0;
            chk("write_we", valid_we, 1);
            chk("write_way", valid_way, exp_way);
            chk("write_index", valid_index, idx);
            chk("write_mem_req", mem_req, 0);
            chk("write_no_resp", resp_valid, 0);
            cyc();
            chk("miss_resp_valid", resp_valid, 1);
            chk("miss_resp_hit", resp_hit, 0);
            chk("miss_resp_way", resp_way, exp_way);
            chk("miss_no_we", valid_we, 0);
        end
        m_touch(idx, exp_way);
        $display("txn idx=%0d hit=%0d hw=%0d valid=%b delay=%0d -> resp_hit=%0d resp_way=%0d",
                 idx, h, hw, v, delay, resp_hit, resp_way);
    endtask

    initial begin
        vecs[0] = '{2'd2, 1'b0, 2'd0, 4'b0000, 3, 1'b0, 2'd0};
        vecs[1] = '{2'd1, 1'b0, 2'd0, 4'b1011, 1, 1'b0, 2'd2};
        vecs[2] = '{2'd3, 1'b1, 2'd0, 4'b1111, 1, 1'b1, 2'd0};
        vecs[3] = '{2'd3, 1'b1, 2'd1, 4'b1111, 1, 1'b1, 2'd1};
        vecs[4] = '{2'd3, 1'b1, 2'd2, 4'b1111, 1, 1'b1, 2'd2};
        vecs[5] = '{2'd3, 1'b0, 2'd0, 4'b1111, 2, 1'b0, 2'd3};
        vecs[6] = '{2'd3, 1'b1, 2'd3, 4'b1111, 1, 1'b1, 2'd3};
        vecs[7] = '{2'd3, 1'b0, 2'd0, 4'b1111, 1, 1'b0, 2'd0};
        vecs[8] = '{2'd0, 1'b1, 2'd1, 4'b1101, 2, 1'b0, 2'd1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_index = '0;
        hit       = 1'b0;
        hit_way   = '0;
        mem_ack   = 1'b0;
        set_valid(4'b0000);
        m_reset();
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valid_we", valid_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_way", resp_way, 0);
        chk("rst_mem_way", mem_way, 0);
        chk("rst_mem_index", mem_index, 0);

        // Directed vector table.
        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].idx, vecs[i].hit, vecs[i].hw, vecs[i].valid,
                    vecs[i].delay, vecs[i].exp_hit, vecs[i].exp_way);

        // Four back-to-back hits on set 0.
        begin
            logic [1:0] ways [4];
            ways[0] = 2'd0; ways[1] = 2'd2; ways[2] = 2'd3; ways[3] = 2'd1;
            set_valid(4'b1111);
            for (int i = 0; i < 4; i++) begin
                chk("b2b_req_ready", req_ready, 1);
                chk("b2b_no_mem_req", mem_req, 0);
                if (i > 0) begin
                    chk("b2b_resp_valid", resp_valid, 1);
                    chk("b2b_resp_hit", resp_hit, 1);
                    chk("b2b_resp_way", resp_way, ways[i-1]);
                end
                req_valid = 1'b1;
                req_index = 2'd0;
                hit       = 1'b1;
                hit_way   = ways[i];
                m_touch(0, ways[i]);
                cyc();
                $display("b2b hit %0d way=%0d resp_valid=%0d resp_way=%0d",
                         i, ways[i], resp_valid, resp_way);
            end
            req_valid = 1'b0;
            hit       = 1'b0;
            chk("b2b_last_resp_valid", resp_valid, 1);
            chk("b2b_last_resp_way", resp_way, ways[3]);
            chk("b2b_no_mem_req_end", mem_req, 0);
            cyc();
            chk("b2b_pulse_single", resp_valid, 0);
            chk("b2b_resp_hit_held", resp_hit, 1);
        end

        // Randomized lookups against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] idx;
            logic       h;
            logic [1:0] hw;
            logic [3:0] v;
            int         d;
            logic       eh;
            logic [1:0] ew;
            idx = 2'($urandom_range(0, 3));
            h   = 1'($urandom_range(0, 1));
            hw  = 2'($urandom_range(0, 3));
            v   = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            d   = $urandom_range(1, 4);
            eh  = h && v[hw];
            ew  = eh ? hw : 2'(m_victim(idx, v));
            run_txn(idx, h, hw, v, d, eh, ew);
        end

        // Reset while a fill is outstanding.
        chk("rf_ready", req_ready, 1);
        req_valid = 1'b1;
        req_index = 2'd1;
        hit       = 1'b0;
        set_valid(4'b0000);
        cyc();
        req_valid = 1'b0;
        chk("rf_mem_req", mem_req, 1);
        cyc();
        chk("rf_mem_req_held", mem_req, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rf_mem_req_drop", mem_req, 0);
        chk("rf_ready_after", req_ready, 1);
        chk("rf_no_we", valid_we, 0);
        chk("rf_resp_valid", resp_valid, 0);
        chk("rf_resp_hit", resp_hit, 0);
        chk("rf_resp_way", resp_way, 0);
        chk("rf_mem_way", mem_way, 0);
        chk("rf_mem_index", mem_index, 0);
        m_reset();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("rf_late_ack_no_we", valid_we, 0);
        chk("rf_late_ack_no_req", mem_req, 0);
        chk("rf_late_ack_ready", req_ready, 1);
        cyc();
        chk("rf_late_ack_no_we2", valid_we, 0);
        chk("rf_late_ack_no_resp", resp_valid, 0);
        // Ages back to reset order: all-valid miss on set 3 evicts way 3.
        run_txn(2'd3, 1'b0, 2'd0, 4'b1111, 1, 1'b0, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
